pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-counter sequencer that sits downstream of the branch comparator, which produces the `jump` flag.
- Owns the PC and runs a fetch/execute handshake with instruction memory and the execute datapath.
- On each instruction retire it turns the comparator's `jump` decision, plus the call/return controls, into the next fetch address.
- Holds a small return-address stack (RAS) for call/return.

Parameters:
- ADDR_W, 16, width of the PC and all addresses.
- RAS_DEPTH, 4, number of return-address stack entries (power of two, ≥2).
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- fetch_req  output  1  request an instruction fetch at fetch_addr.
- fetch_addr  output  ADDR_W  fetch address; always equals pc.
- fetch_ack  input  1  memory has returned the instruction; completes the fetch.
- instr_valid  output  1  one-cycle pulse: fetched instruction is now in the execute stage.
- exec_done  input  1  execute stage has retired the instruction; branch/call/return inputs are valid this cycle.
- br_en  input  1  retiring instruction is a conditional jump.
- jump  input  1  comparator result for the retiring instruction.
- call  input  1  retiring instruction is a call.
- ret  input  1  retiring instruction is a return.
- target  input  ADDR_W  jump/call destination.
- pc  output  ADDR_W  current program counter.
- ras_overflow  output  1  sticky; a push was attempted while the RAS was full.
- ras_underflow  output  1  sticky; a pop was attempted while the RAS was empty.

Behaviour:
- Reset values:
  - pc=RESET_PC; state=FETCH.
  - fetch_req=0 during reset, asserted from the first edge after reset release.
  - instr_valid=0; RAS pointer=0 (empty); ras_overflow=0; ras_underflow=0.
- States: FETCH, EXEC, UPDATE.
- FETCH:
  - fetch_req=1, fetch_addr=pc.
  - Stay until fetch_ack=1, then go to EXEC.
  - fetch_req drops in the cycle after the ack edge.
- EXEC:
  - instr_valid=1 only in the first EXEC cycle.
  - Wait for exec_done=1.
  - On that edge, latch the next-PC decision and go to UPDATE.
  - exec_done in the same cycle as the instr_valid pulse is legal (single-cycle execute).
- UPDATE:
  - pc takes the latched next PC.
  - Go to FETCH unconditionally.
  - Minimum latency: exec_done edge → new fetch_req high is 2 cycles.
- Next-PC priority, sampled at exec_done. Only these four inputs matter; all other cycles ignore them.
  - ret > call > (br_en & jump) > sequential.
  - ret: pop; next = top of stack. If the stack is empty: next = pc+1, set ras_underflow, pointer unchanged.
  - call: push pc+1; next = target. If the stack is full: no push, next = target anyway, set ras_overflow.
  - br_en & jump: next = target.
  - Otherwise (including br_en & !jump): next = pc+1.
- Arithmetic: pc+1 is modulo 2^ADDR_W, so 16'hFFFF → 16'h0000 with no flag. A call at 16'hFFFF pushes 16'h0000.
- Simultaneous ret & call: ret wins, call is ignored (no push).
- ras_overflow and ras_underflow clear only on reset.
- fetch_ack outside FETCH, or exec_done outside EXEC: ignored, no state change.
- Reset mid-operation, in any state: immediate return to reset values. An outstanding fetch is abandoned and memory must tolerate the dropped fetch_req.
- No combinational path from any input to any output.

Test Plan:
- Reset release, fetch_ack held 1, exec_done held 1, no branches → fetch_addr sequence 0,1,2,3; instr_valid pulses once per instruction; 3-state cycle period.
- At pc=5: br_en=1, jump=1, target=16'h0040 → next fetch_addr=16'h0040. Repeat with jump=0 → next fetch_addr=6.
- Call at pc=10 to 16'h0100, then ret at 16'h0100 → fetches 16'h0100, then 11. Nested calls depth 4 return in LIFO order.
- Five nested calls with RAS_DEPTH=4 → ras_overflow=1 after the 5th call, PC still jumps; a 5th ret after four pops → ras_underflow=1, next pc = pc+1.
- pc=16'hFFFF, sequential retire → next fetch_addr=16'h0000; ret & call together → pop taken, no push.
- Assert reset while in FETCH with fetch_ack held low, and again in EXEC → pc=RESET_PC, flags clear, RAS empty, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: FETCH/EXEC/UPDATE handshake with a return-address stack.
// Retire-to-next-fetch latency is 2 cycles; every output is registered, so no input reaches an output combinationally.
module pc_sequencer #(
    parameter int                 ADDR_W    = 16,
    parameter int                 RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ack,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              br_en,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic              ras_overflow,
    output logic              ras_underflow
);
    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {FETCH, EXEC, UPDATE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] npc_q;
    logic              fetch_req_q;
    logic              instr_valid_q;
    logic              ovf_q;
    logic              unf_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] npc_d;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              ras_full;
    logic              ras_empty;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              unf_set;

    // Next-PC decision for the retiring instruction: ret > call > taken branch > sequential.
    always_comb begin
        pc_inc    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        wr_idx    = ptr_q[IDX_W-1:0];
        top_idx   = wr_idx - IDX_W'(1);
        ras_full  = (ptr_q == PTR_W'(RAS_DEPTH));
        ras_empty = (ptr_q == '0);
        npc_d     = pc_inc;
        push      = 1'b0;
        pop       = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (ret) begin
            if (ras_empty) begin
                unf_set = 1'b1;
            end else begin
                pop   = 1'b1;
                npc_d = ras_q[top_idx];
            end
        end else if (call) begin
            npc_d = target;
            if (ras_full) ovf_set = 1'b1;
            else          push    = 1'b1;
        end else if (br_en && jump) begin
            npc_d = target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            npc_q         <= RESET_PC;
            fetch_req_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            ptr_q         <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    // An ack only completes a fetch that is actually being requested.
                    if (fetch_req_q && fetch_ack) begin
                        state_q       <= EXEC;
                        fetch_req_q   <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end else begin
                        fetch_req_q   <= 1'b1;
                    end
                end
                EXEC: begin
                    instr_valid_q <= 1'b0;
                    if (exec_done) begin
                        state_q <= UPDATE;
                        npc_q   <= npc_d;
                        ovf_q   <= ovf_q | ovf_set;
                        unf_q   <= unf_q | unf_set;
                        if (push) begin
                            ras_q[wr_idx] <= pc_inc;
                            ptr_q         <= ptr_q + PTR_W'(1);
                        end else if (pop) begin
                            ptr_q         <= ptr_q - PTR_W'(1);
                        end
                    end
                end
                UPDATE: begin
                    pc_q        <= npc_q;
                    state_q     <= FETCH;
                    fetch_req_q <= 1'b1;
                end
                default: begin
                    state_q     <= FETCH;
                    fetch_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_req     = fetch_req_q;
    assign fetch_addr    = pc_q;
    assign pc            = pc_q;
    assign instr_valid   = instr_valid_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: held-handshake timing, a directed vector table, randomized retires vs a transaction-level model, and mid-operation resets.
module tb_pc_sequencer;
    logic        clk, reset, fetch_ack, exec_done, br_en, jump, call, ret;
    logic [15:0] target;
    logic        fetch_req, instr_valid, ras_overflow, ras_underflow;
    logic [15:0] fetch_addr, pc;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .instr_valid(instr_valid), .exec_done(exec_done),
        .br_en(br_en), .jump(jump), .call(call), .ret(ret), .target(target),
        .pc(pc), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Transaction-level model: architectural PC, stack as a queue, sticky flags.
    logic [15:0] m_pc;
    logic [15:0] m_stack[$];
    logic        m_of, m_uf;

    typedef struct {
        logic [15:0] exp_pc;
        logic        b, j, c, r;
        logic [15:0] tgt;
        logic        exp_of, exp_uf;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000;
        m_stack.delete();
        m_of = 1'b0;
        m_uf = 1'b0;
    endtask

    task automatic model_retire(input logic b, j, c, r, input logic [15:0] tgt);
        if (r) begin
            if (m_stack.size() == 0) begin
                m_uf = 1'b1;
                m_pc = m_pc + 16'd1;
            end else begin
                m_pc = m_stack.pop_back();
            end
        end else if (c) begin
            if (m_stack.size() == 4) m_of = 1'b1;
            else                     m_stack.push_back(m_pc + 16'd1);
            m_pc = tgt;
        end else if (b && j) begin
            m_pc = tgt;
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic clear_inputs();
        fetch_ack = 1'b0; exec_done = 1'b0; br_en = 1'b0; jump = 1'b0;
        call = 1'b0; ret = 1'b0; target = 16'h0000;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        #1;
        chk("rst_pc", 32'(pc), 32'h0000);
        chk("rst_req", 32'(fetch_req), 32'd0);
        chk("rst_iv", 32'(instr_valid), 32'd0);
        chk("rst_flags", {30'd0, ras_overflow, ras_underflow}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (fetch_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("fetch_timeout", 32'(fetch_req), 32'd1);
    endtask

    // Runs one instruction from an asserted fetch_req to the next FETCH; junk on ignored inputs while waiting.
    task automatic do_instr(input logic b, j, c, r, input logic [15:0] tgt,
                            input int ack_dly, input int exec_dly);
        chk("fetch_addr", 32'(fetch_addr), 32'(m_pc));
        chk("flags", {30'd0, ras_overflow, ras_underflow}, {30'd0, m_of, m_uf});
        for (int k = 0; k < ack_dly; k++) begin
            fetch_ack = 1'b0;
            exec_done = 1'($urandom_range(0, 1));
            ret = 1'($urandom_range(0, 1));
            call = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("req_hold", 32'(fetch_req), 32'd1);
        end
        clear_inputs();
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        chk("iv_pulse", {30'd0, instr_valid, fetch_req}, 32'd2);
        for (int k = 0; k < exec_dly; k++) begin
            fetch_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("iv_once", 32'(instr_valid), 32'd0);
        end
        fetch_ack = 1'b0;
        exec_done = 1'b1; br_en = b; jump = j; call = c; ret = r; target = tgt;
        @(negedge clk);
        clear_inputs();
        model_retire(b, j, c, r, tgt);
        chk("update_idle", {30'd0, fetch_req, instr_valid}, 32'd0);
        @(negedge clk);
        chk("fetch_latency", 32'(fetch_req), 32'd1);
    endtask

    task automatic add(input logic [15:0] p, input logic b, j, c, r,
                       input logic [15:0] t, input logic of, uf);
        vec_t v;
        v.exp_pc = p; v.b = b; v.j = j; v.c = c; v.r = r; v.tgt = t;
        v.exp_of = of; v.exp_uf = uf;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);

        // Held ack/done: expect a 3-cycle period, request first, then the valid pulse, then update.
        reset = 1'b0;
        fetch_ack = 1'b1;
        exec_done = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            logic exp_req, exp_iv;
            logic [15:0] exp_a;
            exp_req = (k >= 1) && ((k - 1) % 3 == 0);
            exp_iv  = (k >= 1) && ((k - 1) % 3 == 1);
            exp_a   = (k >= 1) ? 16'((k - 1) / 3) : 16'h0000;
            chk("run_req", 32'(fetch_req), 32'(exp_req));
            chk("run_iv", 32'(instr_valid), 32'(exp_iv));
            chk("run_addr", 32'(fetch_addr), 32'(exp_a));
            @(negedge clk);
        end
        apply_reset();

        add(16'h0000, 0,0,0,0, 16'h0000, 0,0);
        add(16'h0001, 0,0,0,0, 16'h0000, 0,0);
        add(16'h0002, 0,0,0,0, 16'h0000, 0,0);
        add(16'h0003, 0,0,0,0, 16'h0000, 0,0);
        add(16'h0004, 0,0,0,0, 16'h0000, 0,0);
        add(16'h0005, 1,1,0,0, 16'h0040, 0,0);
        add(16'h0040, 1,1,0,0, 16'h0005, 0,0);
        add(16'h0005, 1,0,0,0, 16'h0040, 0,0);
        add(16'h0006, 1,1,0,0, 16'h000A, 0,0);
        add(16'h000A, 0,0,1,0, 16'h0100, 0,0);
        add(16'h0100, 0,0,0,1, 16'h0000, 0,0);
        add(16'h000B, 0,0,1,0, 16'h0200, 0,0);
        add(16'h0200, 0,0,1,0, 16'h0300, 0,0);
        add(16'h0300, 0,0,1,0, 16'h0400, 0,0);
        add(16'h0400, 0,0,1,0, 16'h0500, 0,0);
        add(16'h0500, 0,0,1,0, 16'h0600, 0,0);
        add(16'h0600, 0,0,0,1, 16'h0000, 1,0);
        add(16'h0401, 0,0,0,1, 16'h0000, 1,0);
        add(16'h0301, 0,0,0,1, 16'h0000, 1,0);
        add(16'h0201, 0,0,0,1, 16'h0000, 1,0);
        add(16'h000C, 0,0,0,1, 16'h0000, 1,0);
        add(16'h000D, 1,1,0,0, 16'hFFFF, 1,1);
        add(16'hFFFF, 0,0,0,0, 16'h0000, 1,1);
        add(16'h0000, 0,0,1,1, 16'h0700, 1,1);
        add(16'h0001, 0,0,0,1, 16'h0000, 1,1);
        add(16'h0002, 1,1,0,0, 16'hFFFF, 1,1);
        add(16'hFFFF, 0,0,1,0, 16'h0800, 1,1);
        add(16'h0800, 0,0,0,1, 16'h0000, 1,1);
        add(16'h0000, 0,0,0,0, 16'h0000, 1,1);

        for (int i = 0; i < tbl.size(); i++) begin
            wait_fetch();
            chk("tbl_pc", 32'(fetch_addr), 32'(tbl[i].exp_pc));
            chk("tbl_flags", {30'd0, ras_overflow, ras_underflow},
                {30'd0, tbl[i].exp_of, tbl[i].exp_uf});
            do_instr(tbl[i].b, tbl[i].j, tbl[i].c, tbl[i].r, tbl[i].tgt, i % 2, i % 3);
        end

        apply_reset();
        for (int i = 0; i < 250; i++) begin
            int sel;
            logic b, j, c, r;
            logic [15:0] t;
            sel = int'($urandom_range(0, 11));
            b = 1'b0; j = 1'b0; c = 1'b0; r = 1'b0;
            if (sel < 3)       r = 1'b1;
            else if (sel < 6)  c = 1'b1;
            else if (sel < 7)  begin r = 1'b1; c = 1'b1; end
            else if (sel < 10) begin b = 1'b1; j = 1'($urandom_range(0, 1)); end
            else               j = 1'($urandom_range(0, 1));
            t = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            wait_fetch();
            do_instr(b, j, c, r, t, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset while waiting for an ack in FETCH, with a non-empty stack.
        wait_fetch();
        do_instr(0, 0, 1, 0, 16'h0900, 0, 0);
        fetch_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_req", 32'(fetch_req), 32'd1);
        apply_reset();
        wait_fetch();
        chk("restart_addr", 32'(fetch_addr), 32'h0000);
        do_instr(0, 0, 0, 1, 16'h0000, 0, 1);
        chk("ras_empty_fetch", {30'd0, ras_overflow, ras_underflow}, 32'd1);

        // Reset in EXEC with a pushed entry.
        wait_fetch();
        do_instr(0, 0, 1, 0, 16'h0050, 1, 0);
        wait_fetch();
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        chk("exec_iv", 32'(instr_valid), 32'd1);
        apply_reset();
        wait_fetch();
        chk("restart_addr2", 32'(fetch_addr), 32'h0000);
        do_instr(0, 0, 0, 1, 16'h0000, 0, 0);
        wait_fetch();
        chk("ras_empty_exec", {16'd0, fetch_addr}, 32'h0001);
        chk("ras_unf_exec", 32'(ras_underflow), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
